// File: rtl/pps_pkg.sv
// Shared types and constants for the PPS timestamp block.
package pps_pkg;

  // Default width of the cycle counter, period and seconds fields.
  localparam int CNT_W_DEF = 32;

  // One queued timestamp record. The seconds field is in the upper half
  // and the period field is in the lower half.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] sec;
    logic [CNT_W_DEF-1:0] period;
  } ts_rec_t;

endpackage

// File: rtl/pps_ts_fifo.sv
// Synchronous record queue for pps_timestamp.
// Push and pop may happen in the same cycle, including when the queue is full.
// The read side is show-ahead: rd_data is the head record whenever the queue
// is not empty, and it reads as zero when the queue is empty.
module pps_ts_fifo
  import pps_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter type rec_t      = ts_rec_t
) (
  input  logic axi_aclk,
  input  logic axi_aresetn,
  input  logic push,
  input  rec_t wr_data,
  input  logic pop,
  output rec_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  rec_t        mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  // Popping a full queue frees the slot that a same-cycle push writes into.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = empty ? rec_t'('0) : mem[rd_ptr[AW-1:0]];

  // Record storage holds data only and has no reset.
  always_ff @(posedge axi_aclk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read and write pointers, with one extra wrap bit that separates full from empty.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pps_timestamp.sv
// PPS timestamp block.
// Detects rising edges of the 1 PPS pulse, counts seconds, and measures the
// number of axi_aclk cycles between edges. Each captured edge queues a
// {sec, period} record for the PS. The block also reports lock, missing PPS
// and queue overflow.
// Optional build macro PPS_SYNC_EN: when it is defined, pps passes through a
// 2-flop synchronizer before edge detection, and the latency from rise to
// ts_tvalid grows from 1 to 3 cycles.
module pps_timestamp
  import pps_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NOMINAL    = 1000000,
  parameter int TOL        = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               axi_aclk,
  input  logic               axi_aresetn,
  input  logic               pps,
  input  logic               enable,
  output logic [2*CNT_W-1:0] ts_tdata,
  output logic               ts_tvalid,
  input  logic               ts_tready,
  output logic               irq,
  output logic [CNT_W-1:0]   sec_count,
  output logic               lock,
  output logic               missing,
  output logic               overflow,
  input  logic               ovf_clr
);

  typedef struct packed {
    logic [CNT_W-1:0] sec;
    logic [CNT_W-1:0] period;
  } rec_t;

  localparam logic [CNT_W-1:0] PER_LO = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] PER_HI = CNT_W'(NOMINAL + TOL);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             pps_s;
  logic             pps_prev_p1;
  logic             rise;
  logic             vld_p0;
  rec_t             rec_p0;
  rec_t             rd_rec;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] period_now;
  logic             first_edge;
  logic             in_tol;
  logic             miss_hit;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

`ifdef PPS_SYNC_EN
  logic pps_p0;
  logic pps_p1;

  // Two-flop synchronizer for an asynchronous pps source.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pps_p0 <= 1'b0;
      pps_p1 <= 1'b0;
    end else begin
      pps_p0 <= pps;
      pps_p1 <= pps_p0;
    end
  end

  assign pps_s = pps_p1;
`else
  assign pps_s = pps;
`endif

  // Stores the previous pps sample so that a multi-cycle pulse yields only one rise.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) pps_prev_p1 <= 1'b0;
    else              pps_prev_p1 <= pps_s;
  end

  assign rise       = pps_s & ~pps_prev_p1;
  assign vld_p0     = rise & enable;
  assign period_now = first_edge ? '0 : cyc;
  assign in_tol     = (period_now >= PER_LO) && (period_now <= PER_HI);
  assign miss_hit   = enable && !rise && (cyc == PER_HI);
  assign pop        = ts_tvalid & ts_tready;
  assign drop       = vld_p0 & fifo_full & ~pop;

  // Builds the record for the edge being captured. Its seconds value is the one that sec_count takes on.
  always_comb begin
    rec_p0        = '0;
    rec_p0.sec    = sec_count + CNT_W'(1);
    rec_p0.period = period_now;
  end

  // Cycle counter and first-edge flag. Disabling capture restarts the measurement.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cyc        <= '0;
      first_edge <= 1'b1;
    end else if (!enable) begin
      cyc        <= '0;
      first_edge <= 1'b1;
    end else if (rise) begin
      cyc        <= CNT_W'(1);
      first_edge <= 1'b0;
    end else begin
      cyc        <= sat_inc(cyc);
    end
  end

  // Seconds count, lock and missing status. A timeout clears lock in the same cycle.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      sec_count <= '0;
      lock      <= 1'b0;
      missing   <= 1'b0;
    end else if (vld_p0) begin
      sec_count <= rec_p0.sec;
      lock      <= !first_edge && in_tol;
      missing   <= 1'b0;
    end else if (miss_hit) begin
      lock      <= 1'b0;
      missing   <= 1'b1;
    end
  end

  // Sticky overflow flag. A drop in the same cycle as ovf_clr wins over the clear.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)  overflow <= 1'b0;
    else if (drop)     overflow <= 1'b1;
    else if (ovf_clr)  overflow <= 1'b0;
  end

  pps_ts_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .rec_t      (rec_t)
  ) u_fifo (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .push        (vld_p0),
    .wr_data     (rec_p0),
    .pop         (pop),
    .rd_data     (rd_rec),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign ts_tvalid = ~fifo_empty;
  assign irq       = ts_tvalid;
  assign ts_tdata  = rd_rec;

endmodule

// File: tb/tb_pps_timestamp.sv
// Directed testbench for pps_timestamp, using NOMINAL=100, TOL=2 and FIFO_DEPTH=4.
module tb_pps_timestamp;

  localparam int CNT_W = 32;

  logic               axi_aclk = 1'b0;
  logic               axi_aresetn;
  logic               pps;
  logic               enable;
  logic [2*CNT_W-1:0] ts_tdata;
  logic               ts_tvalid;
  logic               ts_tready;
  logic               irq;
  logic [CNT_W-1:0]   sec_count;
  logic               lock;
  logic               missing;
  logic               overflow;
  logic               ovf_clr;

  int vectors     = 0;
  int miscompares = 0;

  pps_timestamp #(
    .CNT_W      (CNT_W),
    .NOMINAL    (100),
    .TOL        (2),
    .FIFO_DEPTH (4)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .pps         (pps),
    .enable      (enable),
    .ts_tdata    (ts_tdata),
    .ts_tvalid   (ts_tvalid),
    .ts_tready   (ts_tready),
    .irq         (irq),
    .sec_count   (sec_count),
    .lock        (lock),
    .missing     (missing),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  // One-cycle pps pulse. It returns 1 time unit after the edge that samples the rise.
  task automatic pulse();
    pps = 1'b1;
    step();
    pps = 1'b0;
  endtask

  // Makes the next rise land p edges after the previous one.
  task automatic gap(input int p);
    repeat (p - 1) step();
    pulse();
  endtask

  function automatic logic [63:0] rec(input int unsigned s, input int unsigned p);
    return {s[31:0], p[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    axi_aresetn = 1'b0;
    pps         = 1'b0;
    enable      = 1'b0;
    ts_tready   = 1'b0;
    ovf_clr     = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_tvalid",   64'(ts_tvalid), 64'd0);
    chk("rst_irq",      64'(irq),       64'd0);
    chk("rst_sec",      64'(sec_count), 64'd0);
    chk("rst_lock",     64'(lock),      64'd0);
    chk("rst_missing",  64'(missing),   64'd0);
    chk("rst_overflow", 64'(overflow),  64'd0);
    chk("rst_tdata",    ts_tdata,       64'd0);

    axi_aresetn = 1'b1;
    step();
    enable    = 1'b1;
    ts_tready = 1'b1;
    step();

    // Basic capture: 100-cycle periods with ready held high
    pulse();
    chk("b1_tvalid", 64'(ts_tvalid), 64'd1);
    chk("b1_irq",    64'(irq),       64'd1);
    chk("b1_tdata",  ts_tdata,       rec(1, 0));
    chk("b1_sec",    64'(sec_count), 64'd1);
    chk("b1_lock",   64'(lock),      64'd0);
    step();
    chk("b1_popped", 64'(ts_tvalid), 64'd0);
    gap(99);
    chk("b2_tdata", ts_tdata,   rec(2, 100));
    chk("b2_lock",  64'(lock),  64'd1);
    gap(100);
    chk("b3_tdata", ts_tdata,   rec(3, 100));
    chk("b3_lock",  64'(lock),  64'd1);

    // PPS stops: missing rises 102 edges after the last rise and lock drops
    repeat (101) step();
    chk("m_missing_early", 64'(missing), 64'd0);
    chk("m_lock_early",    64'(lock),    64'd1);
    step();
    chk("m_missing", 64'(missing), 64'd1);
    chk("m_lock",    64'(lock),    64'd0);
    pulse();
    chk("m_tdata_103",   ts_tdata,      rec(4, 103));
    chk("m_missing_clr", 64'(missing),  64'd0);
    chk("m_lock_103",    64'(lock),     64'd0);

    // Lock tolerance boundaries
    gap(97);
    chk("t_tdata_97", ts_tdata,   rec(5, 97));
    chk("t_lock_97",  64'(lock),  64'd0);
    gap(102);
    chk("t_tdata_102",   ts_tdata,     rec(6, 102));
    chk("t_lock_102",    64'(lock),    64'd1);
    chk("t_missing_102", 64'(missing), 64'd0);
    gap(98);
    chk("t_tdata_98", ts_tdata,   rec(7, 98));
    chk("t_lock_98",  64'(lock),  64'd1);

    // Overflow: ready low and six edges
    step();
    ts_tready = 1'b0;
    gap(99);
    gap(100);
    gap(100);
    gap(100);
    chk("o_full_ovf",   64'(overflow),  64'd0);
    chk("o_full_tdata", ts_tdata,       rec(8, 100));
    gap(100);
    chk("o_drop_ovf", 64'(overflow),  64'd1);
    chk("o_drop_sec", 64'(sec_count), 64'd12);
    ovf_clr = 1'b1;
    gap(100);
    ovf_clr = 1'b0;
    chk("o_setwins_ovf", 64'(overflow),  64'd1);
    chk("o_sec",         64'(sec_count), 64'd13);
    chk("o_hold_tdata",  ts_tdata,       rec(8, 100));
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("o_clr_ovf", 64'(overflow), 64'd0);

    // Full queue with a rise in the same cycle as a pop
    repeat (98) step();
    ts_tready = 1'b1;
    pulse();
    ts_tready = 1'b0;
    chk("p_ovf",  64'(overflow), 64'd0);
    chk("p_head", ts_tdata,      rec(9, 100));
    ts_tready = 1'b1;
    chk("d_rec9", ts_tdata, rec(9, 100));
    step();
    chk("d_rec10", ts_tdata, rec(10, 100));
    step();
    chk("d_rec11", ts_tdata, rec(11, 100));
    step();
    chk("d_rec14", ts_tdata, rec(14, 100));
    step();
    chk("d_empty", 64'(ts_tvalid), 64'd0);

    // Reset in the middle of a period with two records queued
    ts_tready = 1'b0;
    gap(50);
    gap(50);
    chk("r_pre_tvalid", 64'(ts_tvalid), 64'd1);
    repeat (20) step();
    axi_aresetn = 1'b0;
    #1;
    chk("r_tvalid", 64'(ts_tvalid), 64'd0);
    chk("r_irq",    64'(irq),       64'd0);
    chk("r_sec",    64'(sec_count), 64'd0);
    chk("r_lock",   64'(lock),      64'd0);
    step();
    axi_aresetn = 1'b1;
    step();
    pulse();
    chk("r_first_tdata", ts_tdata,      rec(1, 0));
    chk("r_first_sec",   64'(sec_count), 64'd1);

    // Disabled capture: queue is kept and drains, sec holds, first flag is set again
    enable = 1'b0;
    step();
    pulse();
    chk("e_sec",    64'(sec_count), 64'd1);
    chk("e_tvalid", 64'(ts_tvalid), 64'd1);
    chk("e_tdata",  ts_tdata,       rec(1, 0));
    ts_tready = 1'b1;
    step();
    chk("e_drained", 64'(ts_tvalid), 64'd0);
    ts_tready = 1'b0;
    enable    = 1'b1;
    repeat (5) step();
    pulse();
    chk("e_reen_tdata", ts_tdata,      rec(2, 0));
    chk("e_reen_sec",   64'(sec_count), 64'd2);
    chk("e_reen_lock",  64'(lock),      64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
